// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : Writeback stage of the Y86-64 pipeline. Commits W-register
//               results (valE/valM) into the 15-entry architectural register
//               file, serves the two combinational decode read ports, tracks
//               processor status with a RUN/HALTED machine and counts retired
//               instructions.
// Ports       : clk, rst (async, active-high)
//               W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  <- W register
//               d_srcA, d_srcB -> d_rvalA, d_rvalB               decode reads
//               Stat, halted, w_exc, retired                     status
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int DATA_W = 64,
    parameter int NREG   = 15,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        W_stat,
    input  logic [3:0]        W_icode,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    input  logic [3:0]        W_dstE,
    input  logic [3:0]        W_dstM,
    input  logic [3:0]        d_srcA,
    input  logic [3:0]        d_srcB,
    output logic [DATA_W-1:0] d_rvalA,
    output logic [DATA_W-1:0] d_rvalB,
    output logic [2:0]        Stat,
    output logic              halted,
    output logic              w_exc,
    output logic [CNT_W-1:0]  retired
);

    // Status codes
    localparam logic [2:0] c_STAT_BUB = 3'd0;
    localparam logic [2:0] c_STAT_AOK = 3'd1;
    localparam logic [2:0] c_STAT_HLT = 3'd2;
    localparam logic [2:0] c_STAT_ADR = 3'd3;
    localparam logic [2:0] c_STAT_INS = 3'd4;

    localparam logic [3:0] c_RNONE = 4'hF;

    // Processor state encoding
    localparam logic [0:0] c_S_RUN    = 1'b0;
    localparam logic [0:0] c_S_HALTED = 1'b1;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [2:0]        r_stat;
    logic [2:0]        w_stat_nxt;
    logic [CNT_W-1:0]  r_retired;
    logic [CNT_W-1:0]  w_retired_nxt;
    logic              w_commit;
    logic              w_we_e;
    logic              w_we_m;
    logic [DATA_W-1:0] w_rval_a;
    logic [DATA_W-1:0] w_rval_b;

    // icode plays no part in writeback; status alone decides commit/halt.
    logic w_unused_icode;
    assign w_unused_icode = ^W_icode;

    // ------------------------------------------------------------------
    // Decode read ports: pure combinational lookup of stored contents.
    // IDs with no matching register (RNONE or >= NREG) fall through to 0.
    // No bypass from W: decode forwarding already covers that path.
    // ------------------------------------------------------------------
    always_comb begin
        w_rval_a = '0;
        w_rval_b = '0;
        for (int i = 0; i < NREG; i++) begin
            if (d_srcA == i[3:0]) w_rval_a = r_regs[i];
            if (d_srcB == i[3:0]) w_rval_b = r_regs[i];
        end
    end

    assign d_rvalA = w_rval_a;
    assign d_rvalB = w_rval_b;

    // ------------------------------------------------------------------
    // Status state machine: next-state / commit decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_stat_nxt    = r_stat;
        w_retired_nxt = r_retired;
        w_commit      = 1'b0;
        case (r_state)
            c_S_RUN: begin
                if (W_stat == c_STAT_AOK) begin
                    w_commit      = 1'b1;
                    w_retired_nxt = r_retired + CNT_W'(1);
                end else if (W_stat != c_STAT_BUB) begin
                    // Exceptional instruction retires but writes nothing.
                    // Undefined codes 5..7 are reported as INS.
                    w_state_nxt   = c_S_HALTED;
                    w_retired_nxt = r_retired + CNT_W'(1);
                    if (W_stat == c_STAT_HLT || W_stat == c_STAT_ADR ||
                        W_stat == c_STAT_INS)
                        w_stat_nxt = W_stat;
                    else
                        w_stat_nxt = c_STAT_INS;
                end
            end
            c_S_HALTED: begin
                // Terminal until reset: everything frozen.
            end
            default: begin
                w_state_nxt = c_S_HALTED;
                w_stat_nxt  = c_STAT_INS;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_RUN;
            r_stat    <= c_STAT_AOK;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_stat    <= w_stat_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Register file write. When both ports target the same register the
    // memory result wins, giving popq %rsp its architectural behaviour.
    // ------------------------------------------------------------------
    assign w_we_e = w_commit && (W_dstE != c_RNONE);
    assign w_we_m = w_commit && (W_dstM != c_RNONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_we_m && (W_dstM == i[3:0]))
                    r_regs[i] <= W_valM;
                else if (w_we_e && (W_dstE == i[3:0]))
                    r_regs[i] <= W_valE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. r_stat is AOK throughout RUN, so it drives Stat directly.
    // w_exc flags any non-bubble, non-AOK status while still running.
    // ------------------------------------------------------------------
    assign Stat    = r_stat;
    assign halted  = (r_state == c_S_HALTED);
    assign retired = r_retired;
    assign w_exc   = (r_state == c_S_RUN) &&
                     (W_stat != c_STAT_BUB) && (W_stat != c_STAT_AOK);

endmodule
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Writeback-stage consumer of the W pipeline register in the Y86-64 pipelined core. It takes W_icode/W_stat/W_valE/W_valM/W_dstE/W_dstM from the W register and commits results into the 15-entry architectural register file. It also serves the decode stage's two combinational read ports. It tracks processor status through a RUN/HALTED state machine and counts retired instructions.

Parameters:
DATA_W, 64, register and data width
NREG, 15, architectural registers (IDs 0..14); ID 15 = RNONE
CNT_W, 32, retired-instruction counter width

Ports:
clk  input  1  pipeline clock, all state updates on posedge
rst  input  1  asynchronous, active-high reset
W_stat  input  3  status of instruction in W (0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS)
W_icode  input  4  icode of instruction in W
W_valE  input  DATA_W  ALU result
W_valM  input  DATA_W  memory result
W_dstE  input  4  destination for valE (15 = none)
W_dstM  input  4  destination for valM (15 = none)
d_srcA  input  4  decode read port A register ID
d_srcB  input  4  decode read port B register ID
d_rvalA  output  DATA_W  register value for srcA
d_rvalB  output  DATA_W  register value for srcB
Stat  output  3  processor status
halted  output  1  1 in HALTED state
w_exc  output  1  combinational: W_stat is HLT, ADR or INS and state is RUN (feeds W_stall / M_bubble control)
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (asynchronous, immediate, including mid-operation): all 15 registers 0, state RUN, Stat=1 (AOK), halted=0, retired=0.
- Reads are combinational from stored contents. ID 15 or any ID ≥ NREG reads 0. There is no internal write-to-read bypass; decode forwarding covers same-cycle W values.
- Write enable: commit only when state=RUN and W_stat=AOK.
  - wE = commit & (W_dstE != 15); wM = commit & (W_dstM != 15).
  - On posedge: wE writes W_valE to reg[W_dstE]; wM writes W_valM to reg[W_dstM].
  - If wE & wM & W_dstE==W_dstM, valM wins (popq %rsp semantics).
- W_stat=BUB (0): no write, no retire, no state change.
- State machine:
  - RUN: W_stat=AOK retires one instruction (retired+1). W_stat in {HLT, ADR, INS} latches Stat<=W_stat, moves to HALTED, counts as retired, and writes no registers. Any other W_stat value (5–7) is treated as INS: Stat<=4, HALTED.
  - HALTED: all writes suppressed, retired frozen, Stat held, halted=1, w_exc=0. The block leaves HALTED only on rst.
- Stat reads AOK (1) while in RUN.
- retired wraps modulo 2^CNT_W without flagging.
- Latency: a value written at edge N is visible on d_rval* right after edge N.
- Input held constant with AOK over multiple cycles (W stalled upstream) re-commits each cycle. Caller must present BUB in W when W is not advancing; this block does not sample W_stall.

Test Plan:
- Reset then read all IDs 0..15 -> every d_rvalA/d_rvalB = 0, Stat=1, halted=0, retired=0.
- AOK, W_dstE=3, W_valE=0x1122334455667788, W_dstM=15 -> after edge, d_srcA=3 reads 0x1122334455667788, retired=1; reg 15 read stays 0.
- AOK, W_dstE=W_dstM=4, valE=0x10, valM=0x20 -> reg4=0x20. Next cycle dstE=5/valE=1 and dstM=6/valM=2 -> reg5=1, reg6=2, retired=2.
- W_stat=BUB for 3 cycles with dstE=7, valE=0xFF -> reg7 unchanged, retired unchanged, state RUN.
- W_stat=ADR, dstM=2, valM=0xDEAD -> w_exc=1 before edge; after edge reg2 unchanged, Stat=3, halted=1, w_exc=0. Further AOK writes to reg2 ignored and retired frozen.
- In HALTED (Stat=2 after HLT), pulse rst asynchronously between edges -> outputs clear immediately to RUN/AOK/0 without waiting for clk. The next AOK write succeeds.
